// File: rtl/mem_access_unit.sv
// M-stage data-memory access controller: req/ack handshake to a multi-cycle memory, StallM to the hazard unit.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses abort with ErrM instead of issuing a word-aligned request.
module mem_access_unit #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallM,
    output logic          ErrM,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);

    localparam int unsigned      CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]    CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          access_c;

    assign access_c  = MemReadM | MemWriteM;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign ReadDataM = rdata_q;
    assign ErrM      = err_q;

`ifndef MEM_ALIGN_CHECK_EN
    // Low address bits are dropped when the alignment check is compiled out.
    logic unused_low_addr;
    assign unused_low_addr = ^ALUOutM[1:0];
`endif

    // Next-state, handshake and stall logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        StallM  = 1'b0;

        case (state_q)
            IDLE: begin
                if (access_c) begin
                    StallM = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    if (ALUOutM[1:0] != 2'b00) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else
`endif
                    begin
                        req_d   = 1'b1;
                        addr_d  = {ALUOutM[AW-1:2], 2'b00};
                        wdata_d = WriteDataM;
                        we_d    = MemWriteM;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                StallM = 1'b1;
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Pipeline advances here; the finished instruction is never relaunched.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a transaction-level model expands each access into per-cycle expected outputs.
// Honours MEM_ALIGN_CHECK_EN when the same macro is defined for the build.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, ErrM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .ErrM       (ErrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall, req, we, err;
        logic [31:0] addr, wdata, rdata;
    } exp_t;

    exp_t expq[$];

    // Architectural view of the unit's registered outputs.
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic push(input string nm, input logic s, input logic r, input logic er);
        exp_t e;
        e.name = nm; e.stall = s; e.req = r; e.err = er;
        e.we = m_we; e.addr = m_addr; e.wdata = m_wdata; e.rdata = m_rdata;
        expq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare every cycle's outputs against the model on the falling edge.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk({e.name, ".StallM"},    32'(StallM),  32'(e.stall));
            chk({e.name, ".bus_req"},   32'(bus_req), 32'(e.req));
            chk({e.name, ".bus_we"},    32'(bus_we),  32'(e.we));
            chk({e.name, ".ErrM"},      32'(ErrM),    32'(e.err));
            chk({e.name, ".bus_addr"},  bus_addr,     e.addr);
            chk({e.name, ".bus_wdata"}, bus_wdata,    e.wdata);
            chk({e.name, ".ReadDataM"}, ReadDataM,    e.rdata);
        end
    end

    task automatic idle(input string nm, input int n, input logic ack);
        for (int i = 0; i < n; i++) begin
            cyc();
            MemReadM = 1'b0; MemWriteM = 1'b0; bus_ack = ack; bus_rdata = 32'hFFFF_FFFF;
            push(nm, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One M-stage access; ack_at is the REQ cycle index carrying bus_ack (-1 = never).
    task automatic access(input string nm, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_at);
        int   k;
        logic to;
        logic mis;
        cyc();
        MemReadM = rd; MemWriteM = wr; ALUOutM = addr; WriteDataM = wdata;
        bus_ack = 1'b0; bus_rdata = ~rdata;
        push({nm, ".launch"}, 1'b1, 1'b0, 1'b0);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        if (mis) begin
            cyc();
            m_rdata = 32'h0;
            push({nm, ".done"}, 1'b0, 1'b0, 1'b1);
            return;
        end
        m_addr = {addr[31:2], 2'b00}; m_we = wr; m_wdata = wdata;
        to = (ack_at < 0) || (ack_at >= TO);
        k  = to ? TO : ack_at + 1;
        for (int j = 0; j < k; j++) begin
            cyc();
            bus_ack   = (j == ack_at);
            bus_rdata = (j == ack_at) ? rdata : ~rdata;
            push({nm, ".req"}, 1'b1, 1'b1, 1'b0);
        end
        cyc();
        bus_ack = 1'b0;
        if (to)       m_rdata = 32'h0;
        else if (!wr) m_rdata = rdata;
        push({nm, ".done"}, 1'b0, 1'b0, to);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0;

        idle("reset", 2, 1'b0);
        chk("pin.reset_rdata", ReadDataM, 32'h0);
        chk("pin.reset_req", 32'(bus_req), 32'h0);
        reset = 1'b1;
        idle("idle0", 1, 1'b0);

        access("ld0", 1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
        chk("pin.ld0_rdata", ReadDataM, 32'hDEAD_BEEF);
        chk("pin.ld0_addr", bus_addr, 32'h0000_0104);

        access("st3", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0BAD_F00D, 3);
        chk("pin.st3_rdata", ReadDataM, 32'hDEAD_BEEF);
        chk("pin.st3_wdata", bus_wdata, 32'h1234_5678);
        chk("pin.st3_we", 32'(bus_we), 32'h1);

        idle("ack_in_idle", 2, 1'b1);

        access("b2b_ld", 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'hA5A5_5A5A, 1);
        access("b2b_st", 1'b0, 1'b1, 32'h0000_000C, 32'hCAFE_0001, 32'h0, 0);
        chk("pin.b2b_rdata", ReadDataM, 32'hA5A5_5A5A);
        chk("pin.b2b_addr", bus_addr, 32'h0000_000C);

        access("rdwr", 1'b1, 1'b1, 32'h0000_0030, 32'h7777_0000, 32'h3333_3333, 0);
        chk("pin.rdwr_rdata", ReadDataM, 32'hA5A5_5A5A);

        access("mis", 1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'h1111_2222, 0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("pin.mis_rdata", ReadDataM, 32'h0);
        chk("pin.mis_err", 32'(ErrM), 32'h1);
`else
        chk("pin.mis_rdata", ReadDataM, 32'h1111_2222);
        chk("pin.mis_addr", bus_addr, 32'h0000_0004);
`endif
        idle("idle1", 1, 1'b0);

        access("ld_pre_to", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h4444_5555, 2);
        access("timeout", 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h9999_9999, -1);
        chk("pin.to_err", 32'(ErrM), 32'h1);
        chk("pin.to_rdata", ReadDataM, 32'h0);
        idle("after_to", 1, 1'b0);

        access("ld_pre_rst", 1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h6666_7777, 0);
        // Reset lands while the request is outstanding; the late ack must be ignored.
        cyc();
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h0000_0050; WriteDataM = 32'h5555_AAAA;
        bus_ack = 1'b0;
        push("rst_mid.launch", 1'b1, 1'b0, 1'b0);
        m_addr = 32'h0000_0050; m_we = 1'b0; m_wdata = 32'h5555_AAAA;
        cyc(); push("rst_mid.req0", 1'b1, 1'b1, 1'b0);
        cyc(); reset = 1'b0; push("rst_mid.req1", 1'b1, 1'b1, 1'b0);
        cyc();
        reset = 1'b1; MemReadM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_rdata = '0;
        push("rst_mid.after", 1'b0, 1'b0, 1'b0);
        chk("pin.rst_req", 32'(bus_req), 32'h0);
        idle("rst_mid.late", 2, 1'b0);
        chk("pin.rst_rdata", ReadDataM, 32'h0);

        access("post_rst", 1'b0, 1'b1, 32'h0000_0100, 32'h0102_0304, 32'h0, 1);
        idle("tail", 2, 1'b0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access controller for the 5-stage pipelined ARM core.
- Sits directly downstream of the datapath's M-stage registers. Consumes ALUOutM, WriteDataM and the M-stage memory controls.
- Runs a req/ack handshake to a multi-cycle data memory and returns ReadDataM for the writeback register.
- Drives StallM to the hazard unit, which freezes F/D/E/M while an access is outstanding.

Parameters:
- DW, 32, data bus width in bits.
- AW, 32, address width in bits.
- TIMEOUT, 255, maximum REQ-state cycles before the access is aborted; 0 disables the timeout.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; asserted when 0.
- MemReadM  input  1  M-stage load.
- MemWriteM  input  1  M-stage store.
- ALUOutM  input  AW  effective address.
- WriteDataM  input  DW  store data.
- ReadDataM  output  DW  load data, registered; consumed by the W-stage read-data register.
- StallM  output  1  access in progress; pipeline must hold.
- ErrM  output  1  one-cycle pulse on access abort.
- bus_req  output  1  request to data memory, registered.
- bus_we  output  1  1 = write, registered.
- bus_addr  output  AW  registered address.
- bus_wdata  output  DW  registered write data.
- bus_ack  input  1  memory completion; sampled only in REQ.
- bus_rdata  input  DW  read data; valid when bus_ack = 1.

Behaviour:
- Reset (reset = 0 at a rising edge):
  - state goes to IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ReadDataM=0, ErrM=0, timeout counter=0.
  - Applies even mid-access: the request is dropped at that edge and any later bus_ack is ignored.
- States: IDLE, REQ, DONE. State is 2-bit and registered.
- IDLE:
  - If MemReadM | MemWriteM:
    - StallM=1, combinational in the same cycle.
    - At the edge: bus_req<=1, bus_addr<=ALUOutM with bits [1:0] forced to 0, bus_wdata<=WriteDataM, bus_we<=MemWriteM.
    - Counter cleared; next state is REQ.
  - Otherwise StallM=0 and the state stays IDLE.
- REQ:
  - StallM=1. bus_addr, bus_we and bus_wdata are held stable.
  - On bus_ack=1:
    - Read: ReadDataM<=bus_rdata. Write: ReadDataM unchanged.
    - bus_req<=0; next state is DONE.
  - On bus_ack=0: counter increments.
  - Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no ack:
    - bus_req<=0, ReadDataM<=0, ErrM<=1 for one cycle; next state is DONE.
- DONE:
  - StallM=0, so the pipeline advances at this edge and the completed instruction leaves M.
  - Next state is IDLE unconditionally. The same instruction is never reissued.
- Latency: ack on the first REQ cycle gives 2 stall cycles and release in the 3rd cycle. Each extra wait cycle adds 1 stall cycle.
- Back-to-back accesses: IDLE is entered after DONE; a new access in M launches immediately. There is a minimum of 1 non-stalled cycle (DONE) between accesses.
- MemReadM & MemWriteM both set: treated as a write; ReadDataM unchanged.
- bus_ack in IDLE or DONE: ignored; no state change.
- ReadDataM holds its value until the next completed load, timeout, or reset.
- StallM is the only combinational output: StallM = (state==IDLE & (MemReadM|MemWriteM)) | (state==REQ).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, an access with ALUOutM[1:0] != 0 issues no bus request.
  - StallM=1 for that cycle; at the edge ReadDataM<=0, ErrM<=1 (one-cycle pulse), state goes to DONE.
- Undefined:
  - No check; bits [1:0] are silently zeroed on bus_addr.
  - ErrM is driven only by the timeout.

Test Plan:
- Load, zero-wait:
  - Stimulus: MemReadM=1, ALUOutM=0x0000_0104, bus_ack on the first REQ cycle with bus_rdata=0xDEAD_BEEF.
  - Response: bus_addr=0x104, bus_we=0, StallM high for 2 cycles then low, ReadDataM=0xDEAD_BEEF in DONE.
- Store, 3 wait cycles:
  - Stimulus: MemWriteM=1, ALUOutM=0x20, WriteDataM=0x1234_5678.
  - Response: bus_we=1, bus_wdata=0x1234_5678 stable for 4 REQ cycles, StallM high for 5 cycles, ReadDataM unchanged.
- Timeout:
  - Stimulus: TIMEOUT=4, load issued, bus_ack never asserted.
  - Response: bus_req drops after 4 REQ cycles, ErrM pulses 1 cycle, ReadDataM=0, StallM released.
- Reset mid-access:
  - Stimulus: reset=0 during REQ; next cycle bus_ack=1 with rdata=0xFFFF_FFFF.
  - Response: bus_req=0 and state IDLE after the reset edge, ack ignored, ReadDataM=0.
- Back-to-back:
  - Stimulus: load 0x8 then store 0xC in consecutive instructions.
  - Response: exactly one DONE cycle between accesses, second bus_req rises the cycle after DONE, no duplicate request for 0x8.
- Misalignment:
  - Stimulus: MEM_ALIGN_CHECK_EN defined, load at 0x6.
  - Response: no bus_req, ErrM pulses, ReadDataM=0.
  - Without the macro: bus_addr=0x4 and a normal access.
